// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: latches a wide value, shows one page-selected
// window of hex digits, and optionally blanks leading zeros.
module seg_scan_display #(
  parameter  int NUM_DIGITS  = 4,
  parameter  int DATA_W      = 64,
  parameter  int REFRESH_DIV = 1024,
  localparam int WIN_W       = 4 * NUM_DIGITS,
  localparam int PAGES       = (DATA_W + WIN_W - 1) / WIN_W,
  localparam int PAGE_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data,
  input  logic [PAGE_W-1:0]     page,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DATA_W-1:0]      latchQ;
  logic [PAGES*WIN_W-1:0] latchExt;
  logic [CNT_W-1:0]       refCnt;
  logic [IDX_W-1:0]       idx;
  logic                   tick;
  logic [WIN_W-1:0]       window;
  logic                   pageValid;
  logic [3:0]             nib;
  logic                   lzBlank;
  logic [NUM_DIGITS-1:0]  anNext;
  logic [6:0]             segNext;

  function automatic logic [6:0] hexToSeg(input logic [3:0] n);
    case (n)
      4'h0:    hexToSeg = 7'h40;
      4'h1:    hexToSeg = 7'h79;
      4'h2:    hexToSeg = 7'h24;
      4'h3:    hexToSeg = 7'h30;
      4'h4:    hexToSeg = 7'h19;
      4'h5:    hexToSeg = 7'h12;
      4'h6:    hexToSeg = 7'h02;
      4'h7:    hexToSeg = 7'h78;
      4'h8:    hexToSeg = 7'h00;
      4'h9:    hexToSeg = 7'h10;
      4'hA:    hexToSeg = 7'h08;
      4'hB:    hexToSeg = 7'h03;
      4'hC:    hexToSeg = 7'h46;
      4'hD:    hexToSeg = 7'h21;
      4'hE:    hexToSeg = 7'h06;
      default: hexToSeg = 7'h0E;
    endcase
  endfunction

  assign tick = (refCnt == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    latchExt = '0;
    latchExt[DATA_W-1:0] = latchQ;
  end

  // Page mux by explicit compare so an out-of-range page never indexes past the latch.
  always_comb begin
    window    = '0;
    pageValid = 1'b0;
    for (int unsigned p = 0; p < PAGES; p++) begin
      if (page == PAGE_W'(p)) begin
        window    = latchExt[p*WIN_W +: WIN_W];
        pageValid = 1'b1;
      end
    end
  end

  always_comb begin
    nib     = 4'h0;
    lzBlank = 1'b0;
    anNext  = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib       = window[k*4 +: 4];
        lzBlank   = blank_lz && (k != 0) && ((window >> (4*k)) == '0);
        anNext[k] = 1'b0;
      end
    end
    segNext = (pageValid && !lzBlank) ? hexToSeg(nib) : 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latchQ <= '0;
      refCnt <= '0;
      idx    <= '0;
      an     <= '1;
      seg    <= 7'h7F;
    end else begin
      if (load) latchQ <= data;
      refCnt <= tick ? '0 : refCnt + CNT_W'(1);
      if (tick) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      an  <= anNext;
      seg <= segNext;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized scoreboard bench for seg_scan_display across four parameter sets,
// with an arithmetic reference model of the scan, windowing and blanking.
module tb_seg_scan_display;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } outT;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam int RD = 4;
  localparam int NDS [4] = '{4, 3, 4, 4};
  localparam int DWS [4] = '{64, 16, 24, 40};

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [63:0] data;
  logic [1:0]  page;
  logic [6:0]  segA, segB, segC, segD;
  logic [3:0]  anA, anC, anD;
  logic [2:0]  anB;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int          phase = 0;
  logic [63:0] mLat [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
  outT         expQ [4][$];

  always #5 clk = ~clk;

  seg_scan_display #(.NUM_DIGITS(4), .DATA_W(64), .REFRESH_DIV(RD)) dutA (
    .clk(clk), .rst(rst), .load(load), .data(data), .page(page),
    .blank_lz(blank_lz), .seg(segA), .an(anA));
  seg_scan_display #(.NUM_DIGITS(3), .DATA_W(16), .REFRESH_DIV(RD)) dutB (
    .clk(clk), .rst(rst), .load(load), .data(data[15:0]), .page(page[0]),
    .blank_lz(blank_lz), .seg(segB), .an(anB));
  seg_scan_display #(.NUM_DIGITS(4), .DATA_W(24), .REFRESH_DIV(RD)) dutC (
    .clk(clk), .rst(rst), .load(load), .data(data[23:0]), .page(page[0]),
    .blank_lz(blank_lz), .seg(segC), .an(anC));
  seg_scan_display #(.NUM_DIGITS(4), .DATA_W(40), .REFRESH_DIV(RD)) dutD (
    .clk(clk), .rst(rst), .load(load), .data(data[39:0]), .page(page),
    .blank_lz(blank_lz), .seg(segD), .an(anD));

  function automatic logic [63:0] maskOf(int dw);
    return (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
  endfunction

  // Expected output for digit idx: shift the latch down to that digit, keep only
  // the nibbles still inside the window, and decide blanking from what remains.
  function automatic outT refOut(int nd, int dw, logic [63:0] lat, int pg, bit blz, int idx);
    int winW;
    int pages;
    logic [63:0] rest;
    outT o;
    winW     = 4 * nd;
    pages    = (dw + winW - 1) / winW;
    o.an     = 8'hFF;
    o.an[idx] = 1'b0;
    if (pg >= pages) begin
      o.seg = 7'h7F;
    end else begin
      rest = (lat >> (pg * winW + 4 * idx)) & ((64'd1 << (4 * (nd - idx))) - 64'd1);
      if (blz && idx > 0 && rest == 64'd0) o.seg = 7'h7F;
      else o.seg = SEG_TAB[rest[3:0]];
    end
    return o;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: inputs only change on the falling edge, so they are stable here.
  always @(posedge clk) begin
    int pg;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      pg = (i == 1 || i == 2) ? int'(page[0]) : int'(page);
      if (rst) expQ[i].push_back('{an: 8'hFF, seg: 7'h7F});
      else expQ[i].push_back(refOut(NDS[i], DWS[i], mLat[i], pg, blank_lz, (phase / RD) % NDS[i]));
    end
    if (rst) begin
      phase = 0;
      for (int i = 0; i < 4; i++) mLat[i] = 64'd0;
    end else begin
      if (load) for (int i = 0; i < 4; i++) mLat[i] = data & maskOf(DWS[i]);
      phase++;
    end
  end

  always @(negedge clk) begin
    outT act [4];
    outT e;
    act[0] = {4'hF, anA, segA};
    act[1] = {5'h1F, anB, segB};
    act[2] = {4'hF, anC, segC};
    act[3] = {4'hF, anD, segD};
    for (int i = 0; i < 4; i++) begin
      if (expQ[i].size() > 0) begin
        e = expQ[i].pop_front();
        check($sformatf("inst%0d.an", i), act[i].an, e.an);
        check($sformatf("inst%0d.seg", i), {1'b0, act[i].seg}, {1'b0, e.seg});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadVal(input logic [63:0] v);
    data = v;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    int pending;
    rst = 1'b1; load = 1'b0; data = '0; page = 2'd0; blank_lz = 1'b0;
    step(3);
    rst = 1'b0;
    step(32);

    loadVal(64'h0000_0000_0000_A1F8);
    step(16);
    data = 64'hFFFF_0000_1234_5555;
    step(16);

    loadVal(64'h1234_5678_9ABC_DEF0);
    page = 2'd3; step(16);
    page = 2'd1; step(9);
    page = 2'd2; step(7);
    page = 2'd0;

    blank_lz = 1'b1;
    loadVal(64'h0000_0000_0000_0050); step(16);
    page = 2'd1; step(8);
    page = 2'd0;
    loadVal(64'h0);                   step(16);
    blank_lz = 1'b0;                  step(16);

    rst = 1'b1; step(1); rst = 1'b0;
    step(9);
    rst = 1'b1; load = 1'b1; data = 64'hDEAD_BEEF_CAFE_F00D;
    step(1);
    rst = 1'b0; load = 1'b0;
    step(20);

    loadVal(64'h0000_00AB_CDEF_1234);
    page = 2'd3; step(16);
    page = 2'd2; step(16);
    page = 2'd1; blank_lz = 1'b1; step(16);
    blank_lz = 1'b0;

    for (int n = 0; n < 300; n++) begin
      data     = {$urandom, $urandom} >> $urandom_range(0, 63);
      load     = ($urandom_range(0, 3) == 0);
      page     = 2'($urandom_range(0, 3));
      blank_lz = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 39) == 0);
      step(1);
    end
    rst = 1'b0; load = 1'b0;
    step(2);
    #1;
    pending = 0;
    for (int i = 0; i < 4; i++) pending += expQ[i].size();
    check("scoreboard_drain", 8'(pending), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DATA_W, default 64: width of the displayable value; minimum 4.
REQ-003 Parameter REFRESH_DIV, default 1024: clock cycles each digit stays active; minimum 2.
REQ-004 Derived constants:
- WIN_W = 4*NUM_DIGITS.
- PAGES = ceil(DATA_W/WIN_W).
- PAGE_W = max(1, ceil(log2(PAGES))).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 load  input  1  capture data into the display latch.
REQ-008 data  input  DATA_W  value to display.
REQ-009 page  input  PAGE_W  selects which WIN_W-bit window of the latched value is shown.
REQ-010 blank_lz  input  1  enables leading-zero blanking.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}; active-low; registered.
REQ-012 an  output  NUM_DIGITS  digit enables; active-low; one-hot-low; registered; an[0] is the rightmost (least significant) digit.

Function
REQ-013 Display latch (DATA_W bits):
- Loads data on an edge where load=1.
- Otherwise holds.
- For windowing, treated as zero-extended to PAGES*WIN_W bits.
REQ-014 Refresh counter:
- Counts 0..REFRESH_DIV-1, then wraps to 0.
- Issues an internal tick on the cycle its value is REFRESH_DIV-1.
REQ-015 Digit index:
- Counts 0..NUM_DIGITS-1.
- Advances by one on each tick.
- Wraps from NUM_DIGITS-1 to 0.
- Holds when NUM_DIGITS=1.
REQ-016 Window = latched bits [page*WIN_W +: WIN_W]. Nibble k of the window belongs to digit k.
REQ-017 Outputs are registered every cycle from the current index, latch, page and blank_lz (1-cycle latency):
- an <= all ones except bit index, which is 0.
- seg <= decode(nibble index), or 7'h7F when that digit is blanked.
REQ-018 Hex decode: 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10, A->7'h08, b->7'h03, C->7'h46, d->7'h21, E->7'h06, F->7'h0E.
REQ-019 Leading-zero blanking (blank_lz=1): digit k>0 is blanked when every window nibble j>=k is zero. Digit 0 is never blanked by this rule.
REQ-020 Out-of-range page: when page >= PAGES, every digit is blanked (seg=7'h7F) while anode scanning continues normally.
REQ-021 Scan independence: load, page and blank_lz changes never reset or stall the refresh counter or the digit index.
REQ-022 Latency:
- A load at edge N changes seg no earlier than edge N+1 and only when that digit is active.
- A page or blank_lz change is visible at the next edge.
REQ-023 Each digit is active for exactly REFRESH_DIV consecutive cycles. The full scan period is NUM_DIGITS*REFRESH_DIV cycles.
REQ-024 No combinational path exists from any input to seg or an.

Reset
REQ-025 On an edge with rst=1:
- latch <= 0.
- refresh counter <= 0.
- index <= 0.
- an <= all ones.
- seg <= 7'h7F.
REQ-026 rst has priority over load on the same edge; the latch stays 0.
REQ-027 On the first edge after rst falls, an[0]=0 and seg shows digit 0 of the zero latch (7'h40). Scanning starts from index 0 with a full REFRESH_DIV dwell.
REQ-028 Reset asserted mid-scan aborts the scan immediately at that edge; no partial dwell is carried over.

Verification (NUM_DIGITS=4, DATA_W=64, REFRESH_DIV=4)
REQ-029 Scan order:
- Stimulus: reset, then run 32 cycles.
- Required: an sequence is E,E,E,E,D,D,D,D,B,B,B,B,7,7,7,7, then repeats.
- Required: seg=7'h40 throughout.
REQ-030 Latch and decode:
- Stimulus: load data=64'h0000_0000_0000_A1F8, page=0.
- Required: digit0=7'h00, digit1=7'h0E, digit2=7'h79, digit3=7'h08.
- Required: a later data change with load=0 has no effect.
REQ-031 Paging:
- Stimulus: load data=64'h1234_5678_9ABC_DEF0; page=3, then page=1.
- Required for page=3: digits3..0 show 1,2,3,4.
- Required for page=1: digits3..0 show 9,A,b,C.
- Required: the change is visible the cycle after page changes.
REQ-032 Leading-zero blanking:
- Stimulus: window=16'h0050, blank_lz=1.
- Required: digit3 and digit2 show 7'h7F, digit1=7'h12, digit0=7'h40.
- Stimulus: window=16'h0000.
- Required: only digit0 lit, showing 7'h40.
- Stimulus: set blank_lz=0.
- Required: all four digits show their decoded values.
REQ-033 Reset priority and mid-scan reset:
- Stimulus: assert rst and load together during the dwell on digit 2.
- Required: next edge an=F, seg=7'h7F, latch=0.
- Required: after release, scanning restarts at an=E with a 4-cycle dwell.
REQ-034 Out-of-range page:
- Stimulus: instantiate NUM_DIGITS=3, DATA_W=16 (PAGES=2, PAGE_W=1) and run a separate instance with NUM_DIGITS=4, DATA_W=24 (PAGES=2).
- Required: the page=1 window is zero-extended to the upper nibbles in both instances.
- Stimulus: drive page >= PAGES in an instance where PAGE_W allows it.
- Required: seg=7'h7F on all digits while an keeps scanning.
